onehot_decoder_scan: RTL and testbench

//   Parametrised, registered N-to-2^N one-hot decoder. It replaces the fixed

---
 rtl/onehot_decoder_scan_if.sv | 29 ++
 rtl/onehot_decoder_scan.sv | 119 +++++++++++
 tb/tb_onehot_decoder_scan.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/onehot_decoder_scan_if.sv
// Handshake and output bundle of the registered one-hot decoder / token scanner.
// The master drives control and select codes; the slave returns the decoded one-hot state.
interface onehot_decoder_scan_if #(
  parameter int SEL_W   = 3,
  parameter int DWELL_W = 8
);
  localparam int NOUT = 1 << SEL_W;

  logic               en;
  logic               mode;
  logic               in_valid;
  logic [SEL_W-1:0]   in_sel;
  logic               in_ready;
  logic [DWELL_W-1:0] dwell;
  logic [NOUT-1:0]    y;
  logic               out_valid;
  logic [SEL_W-1:0]   cur_sel;
  logic               wrap;

  modport master (
    output en, mode, in_valid, in_sel, dwell,
    input  in_ready, y, out_valid, cur_sel, wrap
  );

  modport slave (
    input  en, mode, in_valid, in_sel, dwell,
    output in_ready, y, out_valid, cur_sel, wrap
  );
endinterface

// File: rtl/onehot_decoder_scan.sv
// Registered N-to-2^N one-hot decoder with a SCAN mode that walks a token
// across all outputs, holding each position for dwell+1 cycles.
module onehot_decoder_scan #(
  parameter int SEL_W   = 3,
  parameter int DWELL_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  onehot_decoder_scan_if.slave bus
);
  localparam int NOUT = 1 << SEL_W;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_SCAN   = 2'd2
  } state_t;

  state_t             r_state;
  logic [NOUT-1:0]    r_y;
  logic               r_out_valid;
  logic [SEL_W-1:0]   r_cur_sel;
  logic               r_wrap;
  logic [DWELL_W-1:0] r_cnt;
  logic               r_scan_restart;

  logic               w_accept;
  logic [SEL_W-1:0]   w_next_sel;

  function automatic logic [NOUT-1:0] onehot(input logic [SEL_W-1:0] sel);
    logic [NOUT-1:0] v;
    v      = '0;
    v[sel] = 1'b1;
    return v;
  endfunction

  assign w_accept   = (r_state == S_DECODE) && bus.in_valid;
  assign w_next_sel = r_cur_sel + 1'b1;

  // A DECODE->SCAN switch still honours that cycle's accept; the scan
  // restart is deferred one edge via r_scan_restart so the code is visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_y            <= '0;
      r_out_valid    <= 1'b0;
      r_cur_sel      <= '0;
      r_wrap         <= 1'b0;
      r_cnt          <= '0;
      r_scan_restart <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      if (!bus.en) begin
        r_state        <= S_IDLE;
        r_y            <= '0;
        r_out_valid    <= 1'b0;
        r_cnt          <= '0;
        r_scan_restart <= 1'b0;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            if (bus.mode) begin
              r_state        <= S_SCAN;
              r_y            <= onehot(SEL_W'(0));
              r_cur_sel      <= '0;
              r_out_valid    <= 1'b1;
              r_cnt          <= '0;
              r_scan_restart <= 1'b0;
            end else begin
              r_state     <= S_DECODE;
              r_y         <= '0;
              r_out_valid <= 1'b0;
            end
          end
          S_DECODE: begin
            if (w_accept) begin
              r_y         <= onehot(bus.in_sel);
              r_cur_sel   <= bus.in_sel;
              r_out_valid <= 1'b1;
            end
            if (bus.mode) begin
              r_state        <= S_SCAN;
              r_scan_restart <= 1'b1;
            end
          end
          S_SCAN: begin
            if (!bus.mode) begin
              r_state        <= S_DECODE;
              r_y            <= '0;
              r_out_valid    <= 1'b0;
              r_scan_restart <= 1'b0;
            end else if (r_scan_restart) begin
              r_y            <= onehot(SEL_W'(0));
              r_cur_sel      <= '0;
              r_out_valid    <= 1'b1;
              r_cnt          <= '0;
              r_scan_restart <= 1'b0;
            end else if (r_cnt == bus.dwell) begin
              r_cnt       <= '0;
              r_cur_sel   <= w_next_sel;
              r_y         <= onehot(w_next_sel);
              r_out_valid <= 1'b1;
              r_wrap      <= (w_next_sel == '0);
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.in_ready  = (r_state == S_DECODE);
  assign bus.y         = r_y;
  assign bus.out_valid = r_out_valid;
  assign bus.cur_sel   = r_cur_sel;
  assign bus.wrap      = r_wrap;
endmodule

// File: tb/tb_onehot_decoder_scan.sv
// Scoreboard bench for onehot_decoder_scan: SEL_W=3 main checks plus
// SEL_W=1 and SEL_W=6 regressions sharing one clock and reset.
module tb_onehot_decoder_scan;
  logic clk;
  logic rst_n;

  onehot_decoder_scan_if #(.SEL_W(3), .DWELL_W(8)) b3 ();
  onehot_decoder_scan_if #(.SEL_W(1), .DWELL_W(4)) b1 ();
  onehot_decoder_scan_if #(.SEL_W(6), .DWELL_W(8)) b6 ();

  onehot_decoder_scan #(.SEL_W(3), .DWELL_W(8)) dut3 (.clk(clk), .rst_n(rst_n), .bus(b3.slave));
  onehot_decoder_scan #(.SEL_W(1), .DWELL_W(4)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
  onehot_decoder_scan #(.SEL_W(6), .DWELL_W(8)) dut6 (.clk(clk), .rst_n(rst_n), .bus(b6.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] y;
    int          sel;
    logic        ov;
    logic        wrap;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [63:0] y, input int sel, input logic ov, input logic wrap);
    exp_t e;
    e.y = y; e.sel = sel; e.ov = ov; e.wrap = wrap;
    q.push_back(e);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    b3.en = 0; b3.mode = 0; b3.in_valid = 0; b3.in_sel = '0; b3.dwell = '0;
    b1.en = 0; b1.mode = 0; b1.in_valid = 0; b1.in_sel = '0; b1.dwell = '0;
    b6.en = 0; b6.mode = 0; b6.in_valid = 0; b6.in_sel = '0; b6.dwell = '0;
    #3;
    n_checks++;
    if (b3.y !== 8'h00 || b3.out_valid !== 1'b0 || b3.cur_sel !== 3'd0 || b3.wrap !== 1'b0 || b3.in_ready !== 1'b0)
      $display("FAIL reset: y=%h ov=%b sel=%0d wrap=%b rdy=%b want 00 0 0 0 0",
               b3.y, b3.out_valid, b3.cur_sel, b3.wrap, b3.in_ready);
    else n_pass++;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_decode_sweep();
    exp_t e;
    b3.en = 1; b3.mode = 0;
    tick();
    n_checks++;
    if (b3.in_ready !== 1'b1 || b3.y !== 8'h00 || b3.out_valid !== 1'b0)
      $display("FAIL decode_entry: rdy=%b y=%h ov=%b want 1 00 0", b3.in_ready, b3.y, b3.out_valid);
    else n_pass++;
    for (int i = 0; i < 8; i++) begin
      b3.in_valid = 1; b3.in_sel = 3'(i);
      push(64'd1 << i, i, 1'b1, 1'b0);
      n_checks++;
      if (b3.in_ready !== 1'b1) $display("FAIL decode_ready[%0d]: rdy=%b want 1", i, b3.in_ready);
      else n_pass++;
      tick();
      e = q.pop_front();
      n_checks++;
      if (64'(b3.y) !== e.y || int'(b3.cur_sel) != e.sel || b3.out_valid !== e.ov)
        $display("FAIL decode_sweep[%0d]: y=%h sel=%0d ov=%b want y=%h sel=%0d ov=%b",
                 i, b3.y, b3.cur_sel, b3.out_valid, e.y, e.sel, e.ov);
      else n_pass++;
    end
  endtask

  task automatic test_decode_hold();
    b3.in_valid = 1; b3.in_sel = 3'd5;
    tick();
    b3.in_valid = 0;
    for (int i = 0; i < 10; i++) begin
      b3.in_sel = 3'($urandom_range(0, 7));
      push(64'h20, 5, 1'b1, 1'b0);
      tick();
      begin
        exp_t e;
        e = q.pop_front();
        n_checks++;
        if (64'(b3.y) !== e.y || int'(b3.cur_sel) != e.sel || b3.out_valid !== e.ov)
          $display("FAIL decode_hold[%0d]: y=%h sel=%0d ov=%b want y=%h sel=%0d ov=%b",
                   i, b3.y, b3.cur_sel, b3.out_valid, e.y, e.sel, e.ov);
        else n_pass++;
      end
    end
  endtask

  // Reference scan model: counter 0..dwell, advance and flag wrap at 0.
  task automatic scan_run3(input int cycles, input int dwell, inout int m_sel, inout int m_cnt,
                           inout int n_wrap, input string name);
    exp_t e;
    logic w;
    b3.dwell = 8'(dwell);
    for (int i = 0; i < cycles; i++) begin
      b3.in_valid = $urandom_range(0, 1); b3.in_sel = 3'($urandom_range(0, 7));
      if (m_cnt == dwell) begin
        m_cnt = 0; m_sel = (m_sel + 1) % 8; w = (m_sel == 0);
      end else begin
        m_cnt++; w = 1'b0;
      end
      if (w) n_wrap++;
      push(64'd1 << m_sel, m_sel, 1'b1, w);
      tick();
      e = q.pop_front();
      n_checks++;
      if (64'(b3.y) !== e.y || int'(b3.cur_sel) != e.sel || b3.out_valid !== e.ov || b3.wrap !== e.wrap)
        $display("FAIL %s[%0d]: y=%h sel=%0d ov=%b wrap=%b want y=%h sel=%0d ov=%b wrap=%b",
                 name, i, b3.y, b3.cur_sel, b3.out_valid, b3.wrap, e.y, e.sel, e.ov, e.wrap);
      else n_pass++;
    end
  endtask

  task automatic test_scan();
    int m_sel = 0, m_cnt = 0, n_wrap = 0;
    b3.en = 0; b3.in_valid = 0;
    tick();
    b3.en = 1; b3.mode = 1; b3.dwell = 8'd2;
    tick();
    n_checks++;
    if (b3.y !== 8'h01 || b3.out_valid !== 1'b1 || b3.wrap !== 1'b0 || b3.in_ready !== 1'b0)
      $display("FAIL scan_entry: y=%h ov=%b wrap=%b rdy=%b want 01 1 0 0", b3.y, b3.out_valid, b3.wrap, b3.in_ready);
    else n_pass++;
    scan_run3(48, 2, m_sel, m_cnt, n_wrap, "scan_dwell2");
    n_checks++;
    if (n_wrap != 2) $display("FAIL scan_wrap_count: got %0d want 2", n_wrap);
    else n_pass++;
    scan_run3(20, 0, m_sel, m_cnt, n_wrap, "scan_dwell0");
  endtask

  task automatic test_reset_mid_scan();
    n_checks++;
    if (b3.cur_sel === 3'd0) $display("FAIL reset_precond: sel=%0d want nonzero", b3.cur_sel);
    else n_pass++;
    rst_n = 1'b0;
    #2;
    n_checks++;
    if (b3.y !== 8'h00 || b3.out_valid !== 1'b0 || b3.cur_sel !== 3'd0 || b3.wrap !== 1'b0)
      $display("FAIL reset_mid_scan: y=%h ov=%b sel=%0d wrap=%b want 00 0 0 0",
               b3.y, b3.out_valid, b3.cur_sel, b3.wrap);
    else n_pass++;
    tick();
    rst_n = 1'b1;
    b3.mode = 1; b3.dwell = 8'd0;
    tick();
    n_checks++;
    if (b3.y !== 8'h01 || b3.out_valid !== 1'b1 || b3.cur_sel !== 3'd0)
      $display("FAIL reset_restart: y=%h ov=%b sel=%0d want 01 1 0", b3.y, b3.out_valid, b3.cur_sel);
    else n_pass++;
  endtask

  task automatic test_mode_switch();
    b3.en = 0; b3.in_valid = 0;
    tick();
    b3.en = 1; b3.mode = 1; b3.dwell = 8'd0;
    tick();
    repeat (4) tick();
    n_checks++;
    if (b3.y !== 8'h10 || b3.cur_sel !== 3'd4) $display("FAIL mode_pre: y=%h sel=%0d want 10 4", b3.y, b3.cur_sel);
    else n_pass++;
    b3.mode = 0;
    tick();
    n_checks++;
    if (b3.y !== 8'h00 || b3.out_valid !== 1'b0 || b3.in_ready !== 1'b1 || b3.wrap !== 1'b0)
      $display("FAIL mode_to_decode: y=%h ov=%b rdy=%b wrap=%b want 00 0 1 0", b3.y, b3.out_valid, b3.in_ready, b3.wrap);
    else n_pass++;
    b3.mode = 1; b3.in_valid = 1; b3.in_sel = 3'd6;
    tick();
    b3.in_valid = 0;
    n_checks++;
    if (b3.y !== 8'h40 || b3.cur_sel !== 3'd6 || b3.in_ready !== 1'b0)
      $display("FAIL mode_switch_accept: y=%h sel=%0d rdy=%b want 40 6 0", b3.y, b3.cur_sel, b3.in_ready);
    else n_pass++;
    tick();
    n_checks++;
    if (b3.y !== 8'h01 || b3.cur_sel !== 3'd0 || b3.out_valid !== 1'b1)
      $display("FAIL mode_scan_restart: y=%h sel=%0d ov=%b want 01 0 1", b3.y, b3.cur_sel, b3.out_valid);
    else n_pass++;
    tick();
    n_checks++;
    if (b3.y !== 8'h02) $display("FAIL mode_scan_step: y=%h want 02", b3.y);
    else n_pass++;
  endtask

  task automatic test_enable_drop();
    b3.en = 0;
    tick();
    b3.en = 1; b3.mode = 0;
    tick();
    b3.in_valid = 1; b3.in_sel = 3'd3;
    tick();
    n_checks++;
    if (b3.y !== 8'h08) $display("FAIL en_pre: y=%h want 08", b3.y);
    else n_pass++;
    b3.en = 0; b3.in_sel = 3'd7;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if (b3.y !== 8'h00 || b3.out_valid !== 1'b0 || b3.in_ready !== 1'b0 || b3.cur_sel !== 3'd3)
        $display("FAIL en_drop[%0d]: y=%h ov=%b rdy=%b sel=%0d want 00 0 0 3",
                 i, b3.y, b3.out_valid, b3.in_ready, b3.cur_sel);
      else n_pass++;
    end
    b3.in_valid = 0;
  endtask

  task automatic test_sel1();
    exp_t e;
    int m_sel = 0, m_cnt = 0;
    logic w;
    b1.en = 1; b1.mode = 0;
    tick();
    for (int i = 0; i < 2; i++) begin
      b1.in_valid = 1; b1.in_sel = 1'(i);
      push(64'd1 << i, i, 1'b1, 1'b0);
      tick();
      e = q.pop_front();
      n_checks++;
      if (64'(b1.y) !== e.y || int'(b1.cur_sel) != e.sel)
        $display("FAIL sel1_decode[%0d]: y=%h sel=%0d want y=%h sel=%0d", i, b1.y, b1.cur_sel, e.y, e.sel);
      else n_pass++;
    end
    b1.in_valid = 0; b1.en = 0;
    tick();
    b1.en = 1; b1.mode = 1; b1.dwell = 4'd1;
    tick();
    for (int i = 0; i < 10; i++) begin
      if (m_cnt == 1) begin m_cnt = 0; m_sel = (m_sel + 1) % 2; w = (m_sel == 0); end
      else begin m_cnt++; w = 1'b0; end
      push(64'd1 << m_sel, m_sel, 1'b1, w);
      tick();
      e = q.pop_front();
      n_checks++;
      if (64'(b1.y) !== e.y || int'(b1.cur_sel) != e.sel || b1.wrap !== e.wrap)
        $display("FAIL sel1_scan[%0d]: y=%h sel=%0d wrap=%b want y=%h sel=%0d wrap=%b",
                 i, b1.y, b1.cur_sel, b1.wrap, e.y, e.sel, e.wrap);
      else n_pass++;
    end
    b1.en = 0;
  endtask

  task automatic test_sel6();
    exp_t e;
    int m_sel = 0;
    b6.en = 1; b6.mode = 0;
    tick();
    for (int i = 0; i < 64; i++) begin
      b6.in_valid = 1; b6.in_sel = 6'(i);
      push(64'd1 << i, i, 1'b1, 1'b0);
      tick();
      e = q.pop_front();
      n_checks++;
      if (b6.y !== e.y || int'(b6.cur_sel) != e.sel || b6.out_valid !== e.ov)
        $display("FAIL sel6_decode[%0d]: y=%h sel=%0d want y=%h sel=%0d", i, b6.y, b6.cur_sel, e.y, e.sel);
      else n_pass++;
    end
    b6.in_valid = 0; b6.en = 0;
    tick();
    b6.en = 1; b6.mode = 1; b6.dwell = 8'd0;
    tick();
    for (int i = 0; i < 70; i++) begin
      m_sel = (m_sel + 1) % 64;
      push(64'd1 << m_sel, m_sel, 1'b1, m_sel == 0);
      tick();
      e = q.pop_front();
      n_checks++;
      if (b6.y !== e.y || int'(b6.cur_sel) != e.sel || b6.wrap !== e.wrap)
        $display("FAIL sel6_scan[%0d]: y=%h sel=%0d wrap=%b want y=%h sel=%0d wrap=%b",
                 i, b6.y, b6.cur_sel, b6.wrap, e.y, e.sel, e.wrap);
      else n_pass++;
    end
    b6.en = 0;
  endtask

  initial begin
    test_reset();
    test_decode_sweep();
    test_decode_hold();
    test_scan();
    test_reset_mid_scan();
    test_mode_switch();
    test_enable_drop();
    test_sel1();
    test_sel6();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
